// File: rtl/recovery_lock_controller_if.sv
// Shared clock/event types and the tracker-facing interface of the recovery lock controller.
// The slave modport is the controller side; the master modport is the violation tracker side.
package common_p;
  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom_s;
endpackage

package clks_alot_p;
  typedef struct packed {
    logic rise_edge;
    logic fall_edge;
    logic any_valid_edge;
    logic glitch;
  } recovered_events_s;
endpackage

interface recovery_lock_controller_if;
   clks_alot_p::recovered_events_s io_events_i;
   logic                           drift_violation_i;
   logic                           excessive_drift_violation_i;
   logic                           tracker_en_o;
   logic                           tracker_clear_o;

   modport slave (
      input  io_events_i,
      input  drift_violation_i,
      input  excessive_drift_violation_i,
      output tracker_en_o,
      output tracker_clear_o
   );

   modport master (
      output io_events_i,
      output drift_violation_i,
      output excessive_drift_violation_i,
      input  tracker_en_o,
      input  tracker_clear_o
   );
endinterface

// File: rtl/recovery_lock_controller.sv
// Lock sequencing FSM for the drift-violation tracker: clear, acquire on clean edges,
// hold lock, back off after a loss and fault after too many losses.
module recovery_lock_controller #(
   parameter int ACQ_WIDTH  = 8,
   parameter int HOLD_WIDTH = 16,
   parameter int LOSS_WIDTH = 4
) (
   input  common_p::clk_dom_s          sys_dom_i,
   input  logic                        recovery_en_i,
   input  logic [ACQ_WIDTH-1:0]        acquire_edges_i,
   input  logic [HOLD_WIDTH-1:0]       holdoff_cycles_i,
   input  logic [LOSS_WIDTH-1:0]       max_losses_i,
   input  logic                        fault_ack_i,
   recovery_lock_controller_if.slave   trk,
   output logic                        locked_o,
   output logic                        fault_o,
   output logic                        lock_loss_pulse_o,
   output logic [LOSS_WIDTH-1:0]       loss_count_o,
   output logic [2:0]                  state_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_HOLDOFF = 3'd4,
      ST_FAULT   = 3'd5
   } state_e;

   logic clk;
   logic rst;
   assign clk = sys_dom_i.clk;
   assign rst = sys_dom_i.rst;

   state_e                state_q, state_d;
   logic [ACQ_WIDTH-1:0]  acq_q, acq_d;
   logic [HOLD_WIDTH-1:0] hold_q, hold_d;
   logic [LOSS_WIDTH-1:0] loss_q, loss_d;
   logic                  pulse_q, pulse_d;

   logic [ACQ_WIDTH-1:0]  acq_target;
   logic [ACQ_WIDTH-1:0]  acq_inc;
   logic [HOLD_WIDTH-1:0] hold_load;
   logic [LOSS_WIDTH-1:0] loss_inc;
   logic                  edge_seen;
   logic                  unused_events;

   assign edge_seen     = trk.io_events_i.any_valid_edge;
   assign unused_events = &{1'b0, trk.io_events_i};

   // Zero-valued configs behave as 1; both counters saturate instead of wrapping.
   assign acq_target = (acquire_edges_i == '0) ? ACQ_WIDTH'(1) : acquire_edges_i;
   assign hold_load  = (holdoff_cycles_i == '0) ? HOLD_WIDTH'(1) : holdoff_cycles_i;
   assign acq_inc    = (&acq_q) ? acq_q : acq_q + ACQ_WIDTH'(1);
   assign loss_inc   = (&loss_q) ? loss_q : loss_q + LOSS_WIDTH'(1);

   // NOTE: every signal driven here gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      acq_d   = acq_q;
      hold_d  = hold_q;
      loss_d  = loss_q;
      pulse_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (recovery_en_i) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            acq_d = '0;
            if (!recovery_en_i) state_d = ST_IDLE;
            else                state_d = ST_ACQUIRE;
         end
         ST_ACQUIRE: begin
            if (!recovery_en_i) begin
               state_d = ST_IDLE;
            end else if (trk.excessive_drift_violation_i) begin
               acq_d = '0;
            end else if (edge_seen && trk.drift_violation_i) begin
               acq_d = '0;
            end else if (edge_seen) begin
               acq_d = acq_inc;
               // >= so that lowering the target below the live count locks on the next clean edge.
               if (acq_inc >= acq_target) state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (!recovery_en_i) begin
               state_d = ST_IDLE;
            end else if (trk.excessive_drift_violation_i) begin
               pulse_d = 1'b1;
               loss_d  = loss_inc;
               if ((max_losses_i != '0) && (loss_inc >= max_losses_i)) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_HOLDOFF;
                  hold_d  = hold_load;
               end
            end
         end
         ST_HOLDOFF: begin
            if (!recovery_en_i)               state_d = ST_IDLE;
            else if (hold_q <= HOLD_WIDTH'(1)) state_d = ST_CLEAR;
            else                              hold_d  = hold_q - HOLD_WIDTH'(1);
         end
         ST_FAULT: begin
            if (fault_ack_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Every route into IDLE lands with counters already cleared so outputs read 0 there.
      if (state_d == ST_IDLE) begin
         acq_d  = '0;
         hold_d = '0;
         loss_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acq_q   <= '0;
         hold_q  <= '0;
         loss_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acq_q   <= acq_d;
         hold_q  <= hold_d;
         loss_q  <= loss_d;
         pulse_q <= pulse_d;
      end
   end

   assign trk.tracker_en_o    = (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
   assign trk.tracker_clear_o = (state_q == ST_CLEAR);
   assign locked_o            = (state_q == ST_LOCKED);
   assign fault_o             = (state_q == ST_FAULT);
   assign lock_loss_pulse_o   = pulse_q;
   assign loss_count_o        = loss_q;
   assign state_o             = state_q;

endmodule
